// File: rtl/crc_pkg.sv
// Shared CRC-16-CCITT definitions used by both the serial generator and checker:
// polynomial, preset, checker state encoding and the single-bit LFSR step.
package crc_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam int          FCS_BITS   = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_FCS  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DATA = ST_DATA,
        S_FCS  = ST_FCS,
        S_DONE = ST_DONE
    } chk_state_e;

    // MSB-first serial step: shift left and fold in the polynomial when the feedback bit is set
    function automatic logic [15:0] crc16_step(input logic [15:0] r, input logic d);
        logic fb_s;
        fb_s = r[15] ^ d;
        return {r[14:0], 1'b0} ^ (fb_s ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// Serial CRC-16-CCITT LFSR: preset on i_load, one MSB-first step per enabled bit.
module crc16_lfsr
    import crc_pkg::*;
#(
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic        i_clock,
    input  logic        i_nreset,
    input  logic        i_load,
    input  logic        i_en,
    input  logic        i_data,
    output logic [15:0] o_r
);

    // LFSR register; load takes priority over stepping
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            o_r <= INIT;
        end else if (i_load) begin
            o_r <= INIT;
        end else if (i_en) begin
            o_r <= crc16_step(o_r, i_data);
        end else begin
            o_r <= o_r;
        end
    end

endmodule

// File: rtl/crc16ccitt_checker.sv
// Receive-side CRC-16-CCITT checker: shifts in a serial payload plus FCS and flags a
// zero residue, holding the result until the consumer handshakes it away.
module crc16ccitt_checker
    import crc_pkg::*;
#(
    parameter int          PAYLOAD_BITS = 72,
    parameter logic [15:0] CRC_INIT     = CRC16_INIT
) (
    input  logic                    i_clock,
    input  logic                    i_nreset,
    input  logic                    i_start,
    input  logic                    i_valid,
    input  logic                    i_data,
    output logic                    o_busy,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_pass,
    output logic [PAYLOAD_BITS-1:0] o_payload,
    output logic [15:0]             o_fcs
);

    // The counter is shared by both phases, so it must also reach the FCS length
    localparam int CNT_W = ($clog2(PAYLOAD_BITS + 1) > 5) ? $clog2(PAYLOAD_BITS + 1) : 5;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_FCS  = CNT_W'(FCS_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    chk_state_e              state_r;
    logic [CNT_W-1:0]        count_r;
    logic                    lfsr_load_s;
    logic                    lfsr_en_s;
    logic [15:0]             lfsr_r;
    logic [15:0]             lfsr_next_s;
    logic [PAYLOAD_BITS:0]   payload_ext_s;
    logic [FCS_BITS:0]       fcs_ext_s;

    crc16_lfsr #(
        .INIT (CRC_INIT)
    ) u_lfsr (
        .i_clock  (i_clock),
        .i_nreset (i_nreset),
        .i_load   (lfsr_load_s),
        .i_en     (lfsr_en_s),
        .i_data   (i_data),
        .o_r      (lfsr_r)
    );

    // Residue after the current bit, used to judge the frame on its final FCS bit
    assign lfsr_next_s   = crc16_step(lfsr_r, i_data);
    assign payload_ext_s = {o_payload, i_data};
    assign fcs_ext_s     = {o_fcs, i_data};

    // LFSR control: preset on an accepted start, step on every accepted bit
    always_comb begin
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                lfsr_load_s = i_start;
                lfsr_en_s   = 1'b0;
            end
            S_DATA, S_FCS: begin
                lfsr_load_s = 1'b0;
                lfsr_en_s   = i_valid;
            end
            default: begin
                lfsr_load_s = 1'b0;
                lfsr_en_s   = 1'b0;
            end
        endcase
    end

    // Frame FSM with counter, shift registers and registered result/handshake outputs
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            state_r   <= S_IDLE;
            count_r   <= '0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_pass    <= 1'b0;
            o_payload <= '0;
            o_fcs     <= 16'h0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        state_r <= S_DATA;
                        count_r <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (i_valid) begin
                        o_payload <= payload_ext_s[PAYLOAD_BITS-1:0];
                        if (count_r == LAST_DATA) begin
                            state_r <= S_FCS;
                            count_r <= '0;
                        end else begin
                            count_r <= count_r + CNT_ONE;
                        end
                    end
                end
                S_FCS: begin
                    if (i_valid) begin
                        o_fcs <= fcs_ext_s[FCS_BITS-1:0];
                        if (count_r == LAST_FCS) begin
                            state_r <= S_DONE;
                            count_r <= '0;
                            o_busy  <= 1'b0;
                            o_valid <= 1'b1;
                            o_pass  <= (lfsr_next_s == 16'h0000);
                        end else begin
                            count_r <= count_r + CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_r <= S_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    count_r <= '0;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
